// File: rtl/layer42_train_sequencer_pkg.sv
// Shared types for the 42-class train sequencer: value encoding, class index, FSM states.
package layer42_train_sequencer_pkg;

    typedef logic [7:0] zero2one_t;

    localparam zero2one_t Z2O_ZERO = 8'h00;
    localparam zero2one_t Z2O_ONE  = 8'hFF;

    localparam int NUM_CLASSES = 42;
    typedef logic [5:0] class_idx_t;
    localparam class_idx_t LAST_CLASS = class_idx_t'(NUM_CLASSES - 1);

    typedef enum logic [2:0] {
        IDLE,
        FWD,
        SETTLE_W,
        CAPTURE,
        LEARN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/layer42_train_sequencer_if.sv
// Labelled-sample valid/ready channel into the sequencer.
interface layer42_train_sequencer_if #(
    parameter int N = 16
);
    import layer42_train_sequencer_pkg::*;

    logic                s_valid;
    logic                s_ready;
    zero2one_t [N-1:0]   s_in;
    class_idx_t          s_label;
    logic                train_en;

    modport master (output s_valid, s_in, s_label, train_en, input s_ready);
    modport slave  (input s_valid, s_in, s_label, train_en, output s_ready);

endinterface

// File: rtl/layer42_train_sequencer_argmax42.sv
// Combinational argmax over 42 lanes; strict compare keeps the lowest index on ties.
module argmax42
    import layer42_train_sequencer_pkg::*;
(
    input  zero2one_t [NUM_CLASSES-1:0] vals,
    output class_idx_t                  idx
);

    zero2one_t best;

    always_comb begin
        best = vals[0];
        idx  = '0;
        for (int i = 1; i < NUM_CLASSES; i++) begin
            if (vals[i] > best) begin
                best = vals[i];
                idx  = class_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/layer42_train_sequencer.sv
// Sequences forward/settle/capture/learn around a 42-output layer and keeps prediction stats.
module layer42_train_sequencer
    import layer42_train_sequencer_pkg::*;
#(
    parameter int N            = 16,
    parameter int SETTLE       = 4,
    parameter int LEARN_CYCLES = 1,
    parameter int CW           = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    layer42_train_sequencer_if.slave    s,
    input  logic                        clear_stats,
    output logic                        layer_valid,
    output logic                        layer_learn,
    output zero2one_t [N-1:0]           layer_in,
    output zero2one_t [NUM_CLASSES-1:0] layer_expected,
    input  zero2one_t [NUM_CLASSES-1:0] layer_out,
    output logic                        pred_valid,
    output class_idx_t                  pred_label,
    output logic                        pred_correct,
    output logic [CW-1:0]               sample_count,
    output logic [CW-1:0]               correct_count
);

    localparam int CNT_MAX = (SETTLE > LEARN_CYCLES) ? SETTLE : LEARN_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] LEARN_LD  = CNT_W'(LEARN_CYCLES - 1);

    seq_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    class_idx_t       label_q;
    logic             label_ok_q;
    logic             train_q;
    logic             accept;
    class_idx_t       am_idx;

    // Ready is gated by reset so the channel reads not-ready while reset is held.
    assign s.s_ready = (state == IDLE) && !reset;
    assign accept    = s.s_valid && s.s_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        layer_valid = 1'b0;
        layer_learn = 1'b0;
        pred_valid  = 1'b0;
        case (state)
            IDLE:     if (accept) state_nxt = FWD;
            FWD: begin
                layer_valid = 1'b1;
                cnt_nxt     = SETTLE_LD;
                state_nxt   = SETTLE_W;
            end
            SETTLE_W: begin
                if (cnt == '0) state_nxt = CAPTURE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            CAPTURE: begin
                if (train_q && label_ok_q) begin
                    cnt_nxt   = LEARN_LD;
                    state_nxt = LEARN;
                end else begin
                    state_nxt = DONE;
                end
            end
            LEARN: begin
                layer_learn = 1'b1;
                if (cnt == '0) state_nxt = DONE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            DONE: begin
                pred_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            layer_in     <= '0;
            label_q      <= '0;
            label_ok_q   <= 1'b0;
            train_q      <= 1'b0;
            pred_label   <= '0;
            pred_correct <= 1'b0;
        end else begin
            if (accept) begin
                layer_in   <= s.s_in;
                label_q    <= s.s_label;
                label_ok_q <= (s.s_label <= LAST_CLASS);
                train_q    <= s.train_en;
            end
            if (state == CAPTURE) begin
                pred_label   <= am_idx;
                pred_correct <= label_ok_q && (am_idx == label_q);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_count  <= '0;
            correct_count <= '0;
        end else if (clear_stats) begin
            sample_count  <= '0;
            correct_count <= '0;
        end else if (state == DONE) begin
            sample_count  <= sample_count + 1'b1;
            correct_count <= correct_count + CW'(pred_correct);
        end
    end

    // Target decodes from the held label; an out-of-range label yields an all-zero target.
    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_exp
        assign layer_expected[i] = (label_ok_q && (label_q == class_idx_t'(i))) ? Z2O_ONE : Z2O_ZERO;
    end

    argmax42 u_argmax (
        .vals (layer_out),
        .idx  (am_idx)
    );

endmodule
